// File: rtl/mdu_unit_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings
// (also decoded in D) and the sequencer state type.
package mdu_unit_pkg;

  localparam logic [2:0] MDU_OP_MULT  = 3'd0;
  localparam logic [2:0] MDU_OP_MULTU = 3'd1;
  localparam logic [2:0] MDU_OP_DIV   = 3'd2;
  localparam logic [2:0] MDU_OP_DIVU  = 3'd3;
  localparam logic [2:0] MDU_OP_MTHI  = 3'd4;
  localparam logic [2:0] MDU_OP_MTLO  = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  function automatic logic op_is_mul(input logic [2:0] op);
    return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU);
  endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// Request/result bundle between the E stage and the multiply/divide unit.
interface mdu_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             Flush;
  logic [2:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (output Start, Flush, Op, A, B, input Busy, Done, HI, LO);
  modport slave  (input Start, Flush, Op, A, B, output Busy, Done, HI, LO);
endinterface

// File: rtl/mdu_unit_div_core.sv
// Restoring divider on operand magnitudes with signed fix-up, plus the
// divide-by-zero and most-negative / -1 special cases.
module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic             neg_n, neg_d, div_zero, overflow;
  logic [WIDTH-1:0] mag_n, mag_d, q_mag, r_mag;
  logic [WIDTH:0]   part;

  assign neg_n    = is_signed & dividend[WIDTH-1];
  assign neg_d    = is_signed & divisor[WIDTH-1];
  assign mag_n    = neg_n ? -dividend : dividend;
  assign mag_d    = neg_d ? -divisor : divisor;
  assign div_zero = (divisor == '0);
  assign overflow = is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    part  = '0;
    q_mag = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      part = {part[WIDTH-1:0], mag_n[i]};
      if (part >= {1'b0, mag_d}) begin
        part     = part - {1'b0, mag_d};
        q_mag[i] = 1'b1;
      end
    end
    r_mag = part[WIDTH-1:0];
  end

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  always_comb begin
    quotient  = (neg_n ^ neg_d) ? -q_mag : q_mag;
    remainder = neg_n ? -r_mag : r_mag;
    if (div_zero) begin
      quotient  = '1;
      remainder = dividend;
    end else if (overflow) begin
      quotient  = dividend;
      remainder = '0;
    end
  end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; Busy stalls the front end
// for MULT_CYCLES / DIV_CYCLES after an accepted multiply or divide.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  mdu_unit_if.slave  bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d, load_ops, accept;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] quot, rem;
  logic             mul_signed;
  logic [2*WIDTH-1:0] mul_a, mul_b, product;

  // Lower 2*WIDTH bits of the product of extended operands give both signednesses.
  assign mul_signed = (op_q == MDU_OP_MULT);
  assign mul_a      = {{WIDTH{mul_signed & a_q[WIDTH-1]}}, a_q};
  assign mul_b      = {{WIDTH{mul_signed & b_q[WIDTH-1]}}, b_q};
  assign product    = mul_a * mul_b;

  mdu_div_core #(.WIDTH(WIDTH)) u_div (
    .dividend  (a_q),
    .divisor   (b_q),
    .is_signed (op_q == MDU_OP_DIV),
    .quotient  (quot),
    .remainder (rem)
  );

  assign accept = bus.Start & ~bus.Flush & (state_q == IDLE) & (bus.Op <= MDU_OP_MTLO);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    load_ops = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          case (bus.Op)
            MDU_OP_MULT, MDU_OP_MULTU: begin
              load_ops = 1'b1;
              cnt_d    = CNT_W'(MULT_CYCLES);
              state_d  = RUN;
            end
            MDU_OP_DIV, MDU_OP_DIVU: begin
              load_ops = 1'b1;
              cnt_d    = CNT_W'(DIV_CYCLES);
              state_d  = RUN;
            end
            MDU_OP_MTHI: hi_d = bus.A;
            MDU_OP_MTLO: lo_d = bus.A;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          hi_d    = op_is_mul(op_q) ? product[2*WIDTH-1:WIDTH] : rem;
          lo_d    = op_is_mul(op_q) ? product[WIDTH-1:0]       : quot;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  // NOTE: HI/LO are architectural state and must read zero after reset, so they are reset too.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      op_q    <= MDU_OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      if (load_ops) begin
        op_q <= bus.Op;
        a_q  <= bus.A;
        b_q  <= bus.B;
      end
    end
  end

  assign bus.Busy = (state_q == RUN);
  assign bus.Done = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: stimulus pushes expected HI/LO, a monitor
// pops and compares on every Done pulse.
module tb_mdu_unit;
  import mdu_unit_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  logic Clk;
  logic Reset;
  int   checks;
  int   failures;
  exp_t sb[$];

  mdu_unit_if #(.WIDTH(32)) bus ();

  mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    exp_t e;
    if (Reset && bus.Done) begin
      if (sb.size() == 0) begin
        check("done_without_expect", {31'b0, bus.Done}, 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_hi"}, bus.HI, e.hi);
        check({e.name, "_lo"}, bus.LO, e.lo);
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic flush);
    @(posedge Clk);
    #1;
    bus.Start = 1'b1;
    bus.Flush = flush;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    @(posedge Clk);
    #1;
    bus.Start = 1'b0;
    bus.Flush = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo, input int cycles,
                        input string name);
    int n;
    n = 0;
    sb.push_back('{hi: hi, lo: lo, name: name});
    issue(op, a, b, 1'b0);
    @(negedge Clk);
    while (bus.Busy && n < 100) begin
      n++;
      @(negedge Clk);
    end
    check({name, "_busy_cycles"}, 32'(n), 32'(cycles));
    check({name, "_done"}, {31'b0, bus.Done}, 32'd1);
    @(negedge Clk);
    check({name, "_done_once"}, {31'b0, bus.Done}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    checks    = 0;
    failures  = 0;
    bus.Start = 1'b0;
    bus.Flush = 1'b0;
    bus.Op    = 3'd0;
    bus.A     = '0;
    bus.B     = '0;
    Reset     = 1'b1;
    #3 Reset = 1'b0;
    repeat (2) @(negedge Clk);
    check("reset_hi", bus.HI, 32'd0);
    check("reset_lo", bus.LO, 32'd0);
    check("reset_busy", {31'b0, bus.Busy}, 32'd0);
    check("reset_done", {31'b0, bus.Done}, 32'd0);
    Reset = 1'b1;

    run_op(MDU_OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 5,  "mult_m3x7");
    run_op(MDU_OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div_m7_2");
    run_op(MDU_OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10, "div_7_m2");
    run_op(MDU_OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        10, "div_m7_m2");
    run_op(MDU_OP_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        10, "divu_7_2");
    run_op(MDU_OP_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 10, "div_by_zero");
    run_op(MDU_OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 10, "div_overflow");
    run_op(MDU_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1,        5,  "multu_max");

    // Start while Busy: MTHI issued during RUN must be dropped.
    sb.push_back('{hi: 32'd0, lo: 32'd42, name: "mult_6x7"});
    @(posedge Clk);
    #1;
    bus.Start = 1'b1;
    bus.Op    = MDU_OP_MULT;
    bus.A     = 32'd6;
    bus.B     = 32'd7;
    @(posedge Clk);
    #1;
    bus.Op = MDU_OP_MTHI;
    bus.A  = 32'h1234;
    @(posedge Clk);
    #1;
    bus.Start = 1'b0;
    @(negedge Clk);
    check("run_reads_old_hi", bus.HI, 32'hFFFFFFFE);
    check("run_reads_old_lo", bus.LO, 32'd1);
    n = 0;
    while (bus.Busy && n < 100) begin
      n++;
      @(negedge Clk);
    end
    check("busy_start_done", {31'b0, bus.Done}, 32'd1);
    check("busy_start_hi_kept", bus.HI, 32'd0);

    // Flushed start: nothing happens.
    issue(MDU_OP_MULT, 32'd2, 32'd3, 1'b1);
    @(negedge Clk);
    check("flush_busy", {31'b0, bus.Busy}, 32'd0);
    check("flush_hi", bus.HI, 32'd0);
    check("flush_lo", bus.LO, 32'd42);

    // Back-to-back: DIVU issued in the Done cycle of a MULTU.
    sb.push_back('{hi: 32'd0, lo: 32'd15, name: "multu_3x5"});
    issue(MDU_OP_MULTU, 32'd3, 32'd5, 1'b0);
    n = 0;
    @(negedge Clk);
    while (bus.Busy && n < 100) begin
      n++;
      @(negedge Clk);
    end
    check("b2b_first_done", {31'b0, bus.Done}, 32'd1);
    sb.push_back('{hi: 32'd2, lo: 32'd14, name: "divu_100_7"});
    bus.Start = 1'b1;
    bus.Op    = MDU_OP_DIVU;
    bus.A     = 32'd100;
    bus.B     = 32'd7;
    @(posedge Clk);
    #1;
    bus.Start = 1'b0;
    @(negedge Clk);
    check("b2b_busy_no_bubble", {31'b0, bus.Busy}, 32'd1);
    n = 1;
    @(negedge Clk);
    while (bus.Busy && n < 100) begin
      n++;
      @(negedge Clk);
    end
    check("b2b_div_busy_cycles", 32'(n), 32'd10);
    check("b2b_div_done", {31'b0, bus.Done}, 32'd1);

    // MTLO in IDLE: LO updates at the accepting edge, no Busy or Done.
    issue(MDU_OP_MTLO, 32'hABCD, 32'd0, 1'b0);
    @(negedge Clk);
    check("mtlo_lo", bus.LO, 32'hABCD);
    check("mtlo_hi", bus.HI, 32'd2);
    check("mtlo_busy", {31'b0, bus.Busy}, 32'd0);
    check("mtlo_done", {31'b0, bus.Done}, 32'd0);

    // Reset in the middle of a divide aborts it and clears HI/LO.
    issue(MDU_OP_DIV, 32'd9, 32'd2, 1'b0);
    repeat (3) @(negedge Clk);
    check("pre_reset_busy", {31'b0, bus.Busy}, 32'd1);
    Reset = 1'b0;
    #1;
    check("midrun_reset_hi", bus.HI, 32'd0);
    check("midrun_reset_lo", bus.LO, 32'd0);
    check("midrun_reset_busy", {31'b0, bus.Busy}, 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    run_op(MDU_OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 5, "multu_3x4");

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit for the E stage of the 5-stage MIPS pipeline.
- Owns the HI/LO registers and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Latencies are parametrised; Busy feeds the hazard controller, which stalls F/D while an MD-class instruction sits in D.
- Operands arrive already forwarded, i.e. after the Forward_RS_E/RT_E muxes.

Parameters:
WIDTH, 32, operand and HI/LO width
MULT_CYCLES, 5, cycles Busy stays high after a multiply start (>=1)
DIV_CYCLES, 10, cycles Busy stays high after a divide start (>=1)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
Start  in  1  E-stage instruction is MULT/MULTU/DIV/DIVU/MTHI/MTLO
Flush  in  1  E-stage instruction is being flushed; suppresses Start this cycle
Op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved (no-op)
A  in  WIDTH  forwarded RS value
B  in  WIDTH  forwarded RT value
Busy  out  1  operation in flight (registered)
Done  out  1  one-cycle pulse in the cycle HI/LO take the new result
HI  out  WIDTH  HI register
LO  out  WIDTH  LO register

Behaviour:
- Reset (Reset=0, async): HI=0, LO=0, Busy=0, Done=0, counter=0, state IDLE. Reset mid-operation aborts it; HI/LO stay 0.
- Accept condition: Start & ~Flush & ~Busy & Op<=5. Start while Busy, or with reserved Op, is ignored (hazard logic guarantees this never occurs legally).
- States:
  - IDLE: on accepted MULT/MULTU/DIV/DIVU, latch the operands and Op, load counter with MULT_CYCLES or DIV_CYCLES, go to RUN. Busy=1 from the next edge.
  - IDLE, MTHI/MTLO: HI<=A (MTHI) or LO<=A (MTLO) at the same edge, no Busy, Done=0.
  - RUN: counter decrements each cycle. When counter reaches 1, on the next edge HI/LO<=result, Busy<=0, Done<=1 for one cycle, go to IDLE.
- Timing: a multiply accepted at edge t gives Busy high for exactly MULT_CYCLES cycles and HI/LO valid after edge t+MULT_CYCLES. Divide uses DIV_CYCLES the same way.
- Back-to-back: a new Start is accepted in the cycle Busy falls, i.e. with no bubble.
- HI/LO are never partially updated; reads during RUN return the old values.
- Multiply: 2*WIDTH product; HI=upper WIDTH bits, LO=lower. MULT is signed x signed; MULTU is unsigned.
- Divide: LO=quotient, HI=remainder. DIV truncates toward zero and the remainder takes the dividend's sign; DIVU is unsigned.
- Divide by zero: LO=all ones, HI=A. Busy and Done timing are unchanged.
- Signed overflow (A=most-negative, B=-1): LO=A, HI=0.
- The result may be computed combinationally from latched operands or iteratively (restoring divider); only the cycle-accurate Busy/Done/HI/LO behaviour is required.
- Flush has no effect on an operation already in RUN.

Decomposition:
- Shared package/header:
  - MDU_OP_MULT..MDU_OP_MTLO op encodings, also used by the decoder in D.
  - MDU state constants IDLE/RUN.
- One sub-module is natural: mdu_div_core, an iterative restoring divider with signed fix-up, including the zero and overflow cases.
- The multiply stays inline.

Test Plan:
- Reset=0 mid-RUN of DIV, release -> HI=0, LO=0, Busy=0; a subsequent MULTU 3x4 -> LO=12 after 5 cycles.
- MULT A=-3 (0xFFFFFFFD), B=7 -> Busy high exactly 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFEB; Done pulses once.
- DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 cycles; DIVU 7/2 -> LO=3, HI=1.
- DIV by zero A=5 -> LO=0xFFFFFFFF, HI=5. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start while Busy (MTHI A=0x1234 during RUN) -> ignored, HI=the MULT result; Start with Flush=1 -> no Busy, HI/LO unchanged.
- MULTU completes, new DIVU issued in the Done cycle -> accepted with no bubble; MTLO 0xABCD in IDLE -> LO=0xABCD next edge, Busy stays 0.
